// File: rtl/pong_match_sequencer.sv
// pong_match_sequencer: match flow controller for a VGA pong game.
// It detects frame ticks on the rising edge of iVS and runs the match
// through IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER) -> IDLE.
// It keeps both scores, the serve direction, the winner and the frame countdown.
// Optional feature macro: PONG_PAUSE_EN. It adds the PAUSE state, which freezes
// SERVE/PLAY and is toggled by rising edges of i_pause.
module pong_match_sequencer #(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30,
    parameter int OVER_FRAMES  = 180
) (
    input  logic       iVGA_CLK,
    input  logic       iRST,
    input  logic       iVS,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_point_l,
    input  logic       i_point_r,
    output logic [2:0] o_state,
    output logic       o_physics_en,
    output logic       o_serve,
    output logic       o_serve_dir,
    output logic [3:0] o_score_l,
    output logic [3:0] o_score_r,
    output logic [1:0] o_winner,
    output logic [7:0] o_countdown
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4,
        S_PAUSE = 3'd5
    } state_t;

    localparam logic [3:0] WIN = WIN_SCORE[3:0];
    localparam logic [7:0] SF  = SERVE_FRAMES[7:0];
    localparam logic [7:0] PF  = POINT_FRAMES[7:0];
    localparam logic [7:0] OF  = OVER_FRAMES[7:0];

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [3:0] score_l, score_l_n, score_r, score_r_n;
    logic [1:0] winner, winner_n;
    logic       serve_dir, serve_dir_n;
    logic       serve, serve_n;
    logic       phys, phys_n;
    logic       vs_q, vs_prev;
    logic       tick;

`ifdef PONG_PAUSE_EN
    state_t     saved_state, saved_state_n;
    logic       pause_q, pause_prev;
    logic       pause_edge;

    // Register i_pause and keep its previous value so a held button toggles only once.
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            pause_q    <= 1'b0;
            pause_prev <= 1'b0;
        end else begin
            pause_q    <= i_pause;
            pause_prev <= pause_q;
        end
    end

    assign pause_edge = pause_q & ~pause_prev;
`else
    // Pause is not built in. Tie the input off so the port stays connected.
    logic unused_pause;
    assign unused_pause = i_pause;
`endif

    // Register iVS once, then keep its previous value for rising-edge detection.
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            vs_q    <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            vs_q    <= iVS;
            vs_prev <= vs_q;
        end
    end

    assign tick = vs_q & ~vs_prev;

    // Add one point and saturate at the winning score, so the score never wraps.
    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        if (s >= WIN) return WIN;
        else          return s + 4'd1;
    endfunction

    // State register and all registered outputs.
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            winner    <= 2'b00;
            serve_dir <= 1'b1;
            serve     <= 1'b0;
            phys      <= 1'b0;
`ifdef PONG_PAUSE_EN
            saved_state <= S_IDLE;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            score_l   <= score_l_n;
            score_r   <= score_r_n;
            winner    <= winner_n;
            serve_dir <= serve_dir_n;
            serve     <= serve_n;
            phys      <= phys_n;
`ifdef PONG_PAUSE_EN
            saved_state <= saved_state_n;
`endif
        end
    end

    // Next-state logic. Every path that loads the countdown also changes state,
    // so a tick in the same cycle never decrements the new value.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        score_l_n   = score_l;
        score_r_n   = score_r;
        winner_n    = winner;
        serve_dir_n = serve_dir;
        serve_n     = 1'b0;
`ifdef PONG_PAUSE_EN
        saved_state_n = saved_state;
`endif
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    score_l_n   = 4'd0;
                    score_r_n   = 4'd0;
                    winner_n    = 2'b00;
                    serve_dir_n = 1'b1;
                    cnt_n       = SF;
                    state_n     = S_SERVE;
                end
            end
            S_SERVE: begin
`ifdef PONG_PAUSE_EN
                if (pause_edge) begin
                    saved_state_n = S_SERVE;
                    state_n       = S_PAUSE;
                end else
`endif
                if (tick) begin
                    if (cnt <= 8'd1) begin
                        serve_n = 1'b1;
                        cnt_n   = 8'd0;
                        state_n = S_PLAY;
                    end else begin
                        cnt_n = cnt - 8'd1;
                    end
                end
            end
            S_PLAY: begin
`ifdef PONG_PAUSE_EN
                if (pause_edge) begin
                    saved_state_n = S_PLAY;
                    state_n       = S_PAUSE;
                end else
`endif
                if (i_point_l && i_point_r) begin
                    // A simultaneous score is a replayed point: no score changes.
                    cnt_n   = PF;
                    state_n = S_POINT;
                end else if (i_point_l) begin
                    score_l_n   = sat_inc(score_l);
                    serve_dir_n = 1'b0;
                    cnt_n       = PF;
                    state_n     = S_POINT;
                end else if (i_point_r) begin
                    score_r_n   = sat_inc(score_r);
                    serve_dir_n = 1'b1;
                    cnt_n       = PF;
                    state_n     = S_POINT;
                end
            end
            S_POINT: begin
                if (tick) begin
                    if (cnt <= 8'd1) begin
                        if (score_l == WIN) begin
                            winner_n = 2'b01;
                            cnt_n    = OF;
                            state_n  = S_OVER;
                        end else if (score_r == WIN) begin
                            winner_n = 2'b10;
                            cnt_n    = OF;
                            state_n  = S_OVER;
                        end else begin
                            cnt_n   = SF;
                            state_n = S_SERVE;
                        end
                    end else begin
                        cnt_n = cnt - 8'd1;
                    end
                end
            end
            S_OVER: begin
                if (tick) begin
                    if (cnt <= 8'd1) begin
                        cnt_n   = 8'd0;
                        state_n = S_IDLE;
                    end else begin
                        cnt_n = cnt - 8'd1;
                    end
                end
            end
`ifdef PONG_PAUSE_EN
            S_PAUSE: begin
                if (pause_edge) state_n = saved_state;
            end
`endif
            default: begin
                state_n = S_IDLE;
            end
        endcase
        // Physics runs only while the state stays in PLAY. It rises one cycle
        // after the serve pulse and drops on the same edge that leaves PLAY.
        phys_n = (state == S_PLAY) && (state_n == S_PLAY);
    end

    assign o_state      = state;
    assign o_physics_en = phys;
    assign o_serve      = serve;
    assign o_serve_dir  = serve_dir;
    assign o_score_l    = score_l;
    assign o_score_r    = score_r;
    assign o_winner     = winner;
    assign o_countdown  = cnt;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Directed table-driven bench for pong_match_sequencer with default parameters.
module tb_pong_match_sequencer;

    typedef enum int {A_RESET, A_START, A_TICKS, A_PL, A_PR, A_BOTH, A_RALLY_L, A_RALLY_R} act_t;

    typedef struct {
        string      name;
        act_t       act;
        int         n;
        logic [2:0] st;
        logic [3:0] sl;
        logic [3:0] sr;
        logic [7:0] cd;
        logic [1:0] win;
        logic       dir;
        logic       ph;
        int         sv;
    } vec_t;

    logic       iVGA_CLK = 1'b0;
    logic       iRST = 1'b0;
    logic       iVS = 1'b0;
    logic       i_start = 1'b0;
    logic       i_pause = 1'b0;
    logic       i_point_l = 1'b0;
    logic       i_point_r = 1'b0;
    logic [2:0] o_state;
    logic       o_physics_en, o_serve, o_serve_dir;
    logic [3:0] o_score_l, o_score_r;
    logic [1:0] o_winner;
    logic [7:0] o_countdown;

    int   tests = 0;
    int   fails = 0;
    int   serve_total = 0;
    int   phys_err = 0;
    logic serve_prev = 1'b0;
    vec_t vecs[$];

    pong_match_sequencer dut (
        .iVGA_CLK    (iVGA_CLK),
        .iRST        (iRST),
        .iVS         (iVS),
        .i_start     (i_start),
        .i_pause     (i_pause),
        .i_point_l   (i_point_l),
        .i_point_r   (i_point_r),
        .o_state     (o_state),
        .o_physics_en(o_physics_en),
        .o_serve     (o_serve),
        .o_serve_dir (o_serve_dir),
        .o_score_l   (o_score_l),
        .o_score_r   (o_score_r),
        .o_winner    (o_winner),
        .o_countdown (o_countdown)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    // Count serve pulses. Physics must be low in the serve cycle and high in the next one.
    always @(negedge iVGA_CLK) begin
        if (serve_prev && !o_physics_en) phys_err <= phys_err + 1;
        if (o_serve && o_physics_en)     phys_err <= phys_err + 1;
        if (o_serve)                     serve_total <= serve_total + 1;
        serve_prev <= o_serve;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge iVGA_CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cyc(1); iVS = 1'b1;
            cyc(1); iVS = 1'b0;
            cyc(2);
        end
    endtask

    task automatic point(input logic l, input logic r);
        cyc(1); i_point_l = l; i_point_r = r;
        cyc(1); i_point_l = 1'b0; i_point_r = 1'b0;
        cyc(1);
    endtask

    task automatic add(input string nm, input act_t a, input int n, input logic [2:0] st,
                       input logic [3:0] sl, input logic [3:0] sr, input logic [7:0] cd,
                       input logic [1:0] win, input logic dir, input logic ph, input int sv);
        vec_t v;
        v.name = nm; v.act = a; v.n = n; v.st = st; v.sl = sl; v.sr = sr;
        v.cd = cd; v.win = win; v.dir = dir; v.ph = ph; v.sv = sv;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        case (v.act)
            A_RESET: begin
                cyc(1); iRST = 1'b1;
                cyc(3); iRST = 1'b0;
                cyc(2);
            end
            A_START: begin
                cyc(1); i_start = 1'b1;
                cyc(1); i_start = 1'b0;
                cyc(1);
            end
            A_TICKS: ticks(v.n);
            A_PL:    point(1'b1, 1'b0);
            A_PR:    point(1'b0, 1'b1);
            A_BOTH:  point(1'b1, 1'b1);
            A_RALLY_L, A_RALLY_R: begin
                repeat (v.n) begin
                    ticks(60);
                    point(v.act == A_RALLY_L, v.act == A_RALLY_R);
                    ticks(30);
                end
            end
            default: cyc(1);
        endcase
    endtask

    task automatic check(input vec_t v, input int sv_got);
        tests++;
        if (o_state !== v.st || o_score_l !== v.sl || o_score_r !== v.sr ||
            o_countdown !== v.cd || o_winner !== v.win || o_serve_dir !== v.dir ||
            o_physics_en !== v.ph || sv_got != v.sv) begin
            fails++;
            $display("FAIL %s: got st=%0d sl=%0d sr=%0d cd=%0d win=%0d dir=%0d ph=%0d serves=%0d, want st=%0d sl=%0d sr=%0d cd=%0d win=%0d dir=%0d ph=%0d serves=%0d",
                     v.name, o_state, o_score_l, o_score_r, o_countdown, o_winner, o_serve_dir,
                     o_physics_en, sv_got, v.st, v.sl, v.sr, v.cd, v.win, v.dir, v.ph, v.sv);
        end
    endtask

    initial begin
        int sv0;
        //   name             act        n    st sl sr  cd win dir ph sv
        add("reset",          A_RESET,   0,   0, 0, 0,   0, 0, 1, 0, 0);
        add("start",          A_START,   0,   1, 0, 0,  60, 0, 1, 0, 0);
        add("serve_35",       A_TICKS,  35,   1, 0, 0,  25, 0, 1, 0, 0);
        add("pt_in_serve",    A_PL,      0,   1, 0, 0,  25, 0, 1, 0, 0);
        add("serve_59",       A_TICKS,  24,   1, 0, 0,   1, 0, 1, 0, 0);
        add("serve_launch",   A_TICKS,   1,   2, 0, 0,   0, 0, 1, 1, 1);
        add("start_in_play",  A_START,   0,   2, 0, 0,   0, 0, 1, 1, 0);
        add("point_r",        A_PR,      0,   3, 0, 1,  30, 0, 1, 0, 0);
        add("pt_in_point",    A_PL,      0,   3, 0, 1,  30, 0, 1, 0, 0);
        add("point_to_serve", A_TICKS,  30,   1, 0, 1,  60, 0, 1, 0, 0);
        add("serve2",         A_TICKS,  60,   2, 0, 1,   0, 0, 1, 1, 1);
        add("point_l",        A_PL,      0,   3, 1, 1,  30, 0, 0, 0, 0);
        add("point_l_done",   A_TICKS,  30,   1, 1, 1,  60, 0, 0, 0, 0);
        add("serve3",         A_TICKS,  60,   2, 1, 1,   0, 0, 0, 1, 1);
        add("both_points",    A_BOTH,    0,   3, 1, 1,  30, 0, 0, 0, 0);
        add("both_done",      A_TICKS,  30,   1, 1, 1,  60, 0, 0, 0, 0);
        add("serve4",         A_TICKS,  60,   2, 1, 1,   0, 0, 0, 1, 1);
        add("reset_in_play",  A_RESET,   0,   0, 0, 0,   0, 0, 1, 0, 0);
        add("start2",         A_START,   0,   1, 0, 0,  60, 0, 1, 0, 0);
        add("rally_l_x8",     A_RALLY_L, 8,   1, 8, 0,  60, 0, 0, 0, 8);
        add("serve_9th",      A_TICKS,  60,   2, 8, 0,   0, 0, 0, 1, 1);
        add("point_l_9",      A_PL,      0,   3, 9, 0,  30, 0, 0, 0, 0);
        add("over_left",      A_TICKS,  30,   4, 9, 0, 180, 1, 0, 0, 0);
        add("over_179",       A_TICKS, 179,   4, 9, 0,   1, 1, 0, 0, 0);
        add("over_to_idle",   A_TICKS,   1,   0, 9, 0,   0, 1, 0, 0, 0);
        add("pt_in_idle",     A_PR,      0,   0, 9, 0,   0, 1, 0, 0, 0);
        add("restart",        A_START,   0,   1, 0, 0,  60, 0, 1, 0, 0);
        add("rally_r_x8",     A_RALLY_R, 8,   1, 0, 8,  60, 0, 1, 0, 8);
        add("serve_r9",       A_TICKS,  60,   2, 0, 8,   0, 0, 1, 1, 1);
        add("point_r_9",      A_PR,      0,   3, 0, 9,  30, 0, 1, 0, 0);
        add("over_right",     A_TICKS,  30,   4, 0, 9, 180, 2, 1, 0, 0);

        foreach (vecs[i]) begin
            sv0 = serve_total;
            apply(vecs[i]);
            check(vecs[i], serve_total - sv0);
        end

`ifdef PONG_PAUSE_EN
        begin
            vec_t v;
            v.name = "pause_reset"; v.act = A_RESET; apply(v);
            v.act = A_START; apply(v);
            ticks(35);
            cyc(1); i_pause = 1'b1; cyc(3); i_pause = 1'b0; cyc(2);
            ticks(10);
            tests++;
            if (o_state !== 3'd5 || o_countdown !== 8'd25 || o_physics_en !== 1'b0) begin
                fails++;
                $display("FAIL paused: got st=%0d cd=%0d ph=%0d, want st=5 cd=25 ph=0", o_state, o_countdown, o_physics_en);
            end
            cyc(1); i_pause = 1'b1; cyc(3); i_pause = 1'b0; cyc(2);
            tests++;
            if (o_state !== 3'd1 || o_countdown !== 8'd25) begin
                fails++;
                $display("FAIL unpaused: got st=%0d cd=%0d, want st=1 cd=25", o_state, o_countdown);
            end
            ticks(25);
            v.name = "pause_reset_play"; v.act = A_RESET; v.st = 0; v.sl = 0; v.sr = 0;
            v.cd = 0; v.win = 0; v.dir = 1; v.ph = 0; v.sv = 0;
            sv0 = serve_total;
            apply(v);
            check(v, serve_total - sv0);
        end
`endif

        tests++;
        if (phys_err != 0) begin
            fails++;
            $display("FAIL physics_after_serve: got %0d timing errors, want 0", phys_err);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
